muldiv_sequencer: RTL

- Multi-cycle sequencer for the RV32M operations in the EX stage.
- Replaces the single-cycle combinational multiply/divide path. It latches operands on a start request, runs a fixed-latency multiply or a 32-iteration restoring divide, stalls the pipeline while busy, and returns a one-cycle done pulse with the 32-bit result.
- Sits beside the ALU. The hazard unit ORs stall_o into the IF/ID/EX stall.

---
 rtl/muldiv_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: fixed-depth multiply, 32-step restoring divide, one-cycle done pulse.
// Latency: mul C0+MUL_CYCLES+1, div C0+35, div special cases C0+2; stall_o holds the pipe until done_o.
module muldiv_sequencer #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    localparam logic [CW-1:0]   MUL_LAST  = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0]   ITER_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [4:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] result_q;

    logic is_m_op;
    logic accept;

    assign is_m_op = (op_i >= OP_MUL) && (op_i <= OP_REMU);
    assign accept  = (state == S_IDLE) && start_i && is_m_op && !flush_i;

    // Operation decode from the latched op; mul/div fields only matter in their own states.
    logic a_signed, b_signed, signed_div, is_rem;
    assign a_signed   = (op_q != OP_MULHU);
    assign b_signed   = (op_q == OP_MUL) || (op_q == OP_MULH);
    assign signed_div = (op_q == OP_DIV) || (op_q == OP_REM);
    assign is_rem     = !((op_q == OP_DIV) || (op_q == OP_DIVU));

    logic [2*XLEN-1:0] mul_a, mul_b, mul_full;
    logic [XLEN-1:0]   mul_res;
    assign mul_a    = a_signed ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
    assign mul_b    = b_signed ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    assign mul_full = mul_a * mul_b;
    assign mul_res  = (op_q == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];

    logic div_zero, div_ovf, div_special;
    assign div_zero    = (b_q == '0);
    assign div_ovf     = signed_div && (a_q == INT_MIN) && (b_q == '1);
    assign div_special = div_zero || div_ovf;

    logic [XLEN-1:0] abs_a, abs_b;
    assign abs_a = a_q[XLEN-1] ? -a_q : a_q;
    assign abs_b = b_q[XLEN-1] ? -b_q : b_q;

    // Restoring step: the partial remainder never reaches the divisor, so XLEN+1 bits suffice.
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] step_rem, step_quo;
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign step_rem = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign step_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};

    logic [XLEN-1:0] q_fix, r_fix, fix_res;
    assign q_fix   = (signed_div && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
    assign r_fix   = (signed_div && a_q[XLEN-1]) ? -rem_q : rem_q;
    assign fix_res = is_rem ? r_fix : q_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (op_i >= OP_DIV) ? S_PREP : S_MUL;
            S_MUL: begin
                if (flush_i)                state_nxt = S_IDLE;
                else if (cnt_q == MUL_LAST) state_nxt = S_DONE;
            end
            S_PREP: begin
                if (flush_i)          state_nxt = S_IDLE;
                else if (div_special) state_nxt = S_DONE;
                else                  state_nxt = S_ITER;
            end
            S_ITER: begin
                if (flush_i)                 state_nxt = S_IDLE;
                else if (cnt_q == ITER_LAST) state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = flush_i ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state != S_IDLE);
        done_o   = (state == S_DONE);
        stall_o  = accept || (busy_o && !done_o);
        result_o = result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= op_i;
                        a_q   <= src_a_i;
                        b_q   <= src_b_i;
                        cnt_q <= '0;
                    end
                end
                S_MUL: begin
                    if (!flush_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == MUL_LAST) result_q <= mul_res;
                    end
                end
                S_PREP: begin
                    if (!flush_i) begin
                        if (div_zero) begin
                            result_q <= is_rem ? a_q : '1;
                        end else if (div_ovf) begin
                            result_q <= is_rem ? '0 : INT_MIN;
                        end else begin
                            quo_q <= signed_div ? abs_a : a_q;
                            dvs_q <= signed_div ? abs_b : b_q;
                            rem_q <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                S_ITER: begin
                    if (!flush_i) begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!flush_i) result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule
